// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the fabric configuration loader.
// Optional build macro: CFG_CRC_CHECK_EN (adds the trailing CRC-8 check word).
package fabric_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_CLB,
        LOAD_SB,
        LOAD_CB,
        CHECK,
        FINISH
    } cfg_state_e;

    localparam int DEF_CLB_BITS = 296;   // 8 LUTs x 37 bits
    localparam int DEF_SB_BITS  = 384;
    localparam int DEF_CB_BITS  = 104;   // 8 x 13 bits
    localparam int DEF_WORD_W   = 8;

    localparam logic [7:0] CRC_POLY = 8'h07;

    // One serial CRC-8 step: shift left, fold the poly in when (msb ^ bit) is set.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Word buffer for the configuration loader: accepts one WORD_W word at a
// time and hands it out one bit per pop, LSB first. A new word may be taken
// in the same cycle the last buffered bit is popped, so a steady source
// yields one bit every cycle with no bubbles.
// Optional build macro: CFG_CRC_CHECK_EN (exposes the raw buffered word).
module cfg_word_serializer #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en_i,    // owner is in a state that consumes words
    input  logic              refill_ok_i,  // owner wants another word after this one
    input  logic              pop_i,        // current bit is consumed this cycle
    input  logic              flush_i,      // drop whatever is left in the buffer
    input  logic [WORD_W-1:0] cfg_data_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    output logic              bit_avail_o,
`ifdef CFG_CRC_CHECK_EN
    output logic [WORD_W-1:0] word_o,
`endif
    output logic              bit_o
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              accept;

    assign bit_avail_o = (cnt_q != '0);
    assign bit_o       = buf_q[0];
`ifdef CFG_CRC_CHECK_EN
    assign word_o      = buf_q;
`endif
    assign cfg_ready_o = load_en_i && refill_ok_i &&
                         ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop_i));
    assign accept      = cfg_valid_i && cfg_ready_o;

    // Next buffer contents: flush beats refill beats shift.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (accept) begin
            buf_d = cfg_data_i;
            cnt_d = CNT_W'(WORD_W);
        end else if (pop_i && bit_avail_o) begin
            buf_d = buf_q >> 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Buffer and remaining-bit count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fabric_config_loader.sv
// Fabric configuration loader: streams a packed word sequence, LSB first,
// into the CLB, switch block and connection block shift chains in turn and
// drives the program strobes. The bit stream runs continuously across chain
// boundaries; leftover bits of the final word are dropped.
// Optional build macro: CFG_CRC_CHECK_EN (CRC-8 over all shifted bits,
// checked against one trailing word; requires WORD_W >= 8).
module fabric_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter int CLB_BITS = DEF_CLB_BITS,
    parameter int SB_BITS  = DEF_SB_BITS,
    parameter int CB_BITS  = DEF_CB_BITS,
    parameter int WORD_W   = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              bit_in_clb,
    output logic              bit_in_sb,
    output logic              bit_in_cb,
    output logic              prgm_b,
    output logic              CLB_prgm_b,
    output logic              sb_prgm_b,
    output logic              cb_prgm_b,
    output logic              busy,
    output logic              done,
    output logic              crc_err
);

    localparam int CNT_W = $clog2(max3(CLB_BITS, SB_BITS, CB_BITS) + 1);

    cfg_state_e       state_q, state_d;
    logic [CNT_W-1:0] clb_cnt_q, clb_cnt_d, sb_cnt_q, sb_cnt_d, cb_cnt_q, cb_cnt_d;
    logic             bit_clb_q, bit_clb_d, bit_sb_q, bit_sb_d, bit_cb_q, bit_cb_d;
    logic             en_clb_q, en_clb_d, en_sb_q, en_sb_d, en_cb_q, en_cb_d;
    logic             prgm_b_q, prgm_b_d, busy_q, busy_d, done_q, done_d;
    logic             ser_avail, ser_bit, ser_pop, ser_flush, ser_refill_ok, ser_load_en;
    logic             last_clb, last_sb, last_cb;
`ifdef CFG_CRC_CHECK_EN
    logic [WORD_W-1:0] ser_word;
    logic [7:0]        crc_q, crc_d;
    logic              crc_err_q, crc_err_d;
`endif

    assign last_clb = (clb_cnt_q == CNT_W'(CLB_BITS - 1));
    assign last_sb  = (sb_cnt_q  == CNT_W'(SB_BITS - 1));
    assign last_cb  = (cb_cnt_q  == CNT_W'(CB_BITS - 1));

    assign ser_pop       = (state_q inside {LOAD_CLB, LOAD_SB, LOAD_CB}) && ser_avail;
    // The final chain bit must not pull in another word: it would be flushed.
    assign ser_refill_ok = !((state_q == LOAD_CB) && last_cb && ser_avail);
`ifdef CFG_CRC_CHECK_EN
    assign ser_load_en   = state_q inside {LOAD_CLB, LOAD_SB, LOAD_CB, CHECK};
`else
    assign ser_load_en   = state_q inside {LOAD_CLB, LOAD_SB, LOAD_CB};
`endif

    cfg_word_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_en_i   (ser_load_en),
        .refill_ok_i (ser_refill_ok),
        .pop_i       (ser_pop),
        .flush_i     (ser_flush),
        .cfg_data_i  (cfg_data),
        .cfg_valid_i (cfg_valid),
        .cfg_ready_o (cfg_ready),
        .bit_avail_o (ser_avail),
`ifdef CFG_CRC_CHECK_EN
        .word_o      (ser_word),
`endif
        .bit_o       (ser_bit)
    );

    // Sequencer: next state, chain counters and next values of the output registers.
    always_comb begin
        state_d   = state_q;
        clb_cnt_d = clb_cnt_q;
        sb_cnt_d  = sb_cnt_q;
        cb_cnt_d  = cb_cnt_q;
        bit_clb_d = bit_clb_q;
        bit_sb_d  = bit_sb_q;
        bit_cb_d  = bit_cb_q;
        en_clb_d  = 1'b0;
        en_sb_d   = 1'b0;
        en_cb_d   = 1'b0;
        prgm_b_d  = prgm_b_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ser_flush = 1'b0;
`ifdef CFG_CRC_CHECK_EN
        crc_d     = ser_pop ? crc8_step(crc_q, ser_bit) : crc_q;
        crc_err_d = crc_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = LOAD_CLB;
                    busy_d    = 1'b1;
                    prgm_b_d  = 1'b0;
                    clb_cnt_d = '0;
                    sb_cnt_d  = '0;
                    cb_cnt_d  = '0;
`ifdef CFG_CRC_CHECK_EN
                    crc_d     = 8'h00;
                    crc_err_d = 1'b0;
`endif
                end
            end
            LOAD_CLB: begin
                if (ser_avail) begin
                    {bit_clb_d, bit_sb_d, bit_cb_d} = {ser_bit, 2'b00};
                    en_clb_d  = 1'b1;
                    clb_cnt_d = clb_cnt_q + CNT_W'(1);
                    if (last_clb) state_d = LOAD_SB;
                end
            end
            LOAD_SB: begin
                if (ser_avail) begin
                    {bit_clb_d, bit_sb_d, bit_cb_d} = {1'b0, ser_bit, 1'b0};
                    en_sb_d  = 1'b1;
                    sb_cnt_d = sb_cnt_q + CNT_W'(1);
                    if (last_sb) state_d = LOAD_CB;
                end
            end
            LOAD_CB: begin
                if (ser_avail) begin
                    {bit_clb_d, bit_sb_d, bit_cb_d} = {2'b00, ser_bit};
                    en_cb_d  = 1'b1;
                    cb_cnt_d = cb_cnt_q + CNT_W'(1);
                    if (last_cb) begin
                        ser_flush = 1'b1;   // discard unused high bits of the last word
`ifdef CFG_CRC_CHECK_EN
                        state_d   = CHECK;
`else
                        state_d   = FINISH;
`endif
                    end
                end
            end
`ifdef CFG_CRC_CHECK_EN
            CHECK: begin
                if (ser_avail) begin
                    ser_flush = 1'b1;
                    if (ser_word[7:0] != crc_q) crc_err_d = 1'b1;
                    state_d   = FINISH;
                end
            end
`endif
            FINISH: begin
                state_d  = IDLE;
                prgm_b_d = 1'b1;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                {bit_clb_d, bit_sb_d, bit_cb_d} = 3'b000;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters and registered outputs; reset aborts any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            clb_cnt_q <= '0;
            sb_cnt_q  <= '0;
            cb_cnt_q  <= '0;
            bit_clb_q <= 1'b0;
            bit_sb_q  <= 1'b0;
            bit_cb_q  <= 1'b0;
            en_clb_q  <= 1'b0;
            en_sb_q   <= 1'b0;
            en_cb_q   <= 1'b0;
            prgm_b_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CFG_CRC_CHECK_EN
            crc_q     <= 8'h00;
            crc_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            clb_cnt_q <= clb_cnt_d;
            sb_cnt_q  <= sb_cnt_d;
            cb_cnt_q  <= cb_cnt_d;
            bit_clb_q <= bit_clb_d;
            bit_sb_q  <= bit_sb_d;
            bit_cb_q  <= bit_cb_d;
            en_clb_q  <= en_clb_d;
            en_sb_q   <= en_sb_d;
            en_cb_q   <= en_cb_d;
            prgm_b_q  <= prgm_b_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CFG_CRC_CHECK_EN
            crc_q     <= crc_d;
            crc_err_q <= crc_err_d;
`endif
        end
    end

    assign bit_in_clb = bit_clb_q;
    assign bit_in_sb  = bit_sb_q;
    assign bit_in_cb  = bit_cb_q;
    assign CLB_prgm_b = en_clb_q;
    assign sb_prgm_b  = en_sb_q;
    assign cb_prgm_b  = en_cb_q;
    assign prgm_b     = prgm_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef CFG_CRC_CHECK_EN
    assign crc_err    = crc_err_q;
`else
    assign crc_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
// Bench for fabric_config_loader. Instance A uses the default geometry,
// instance B uses WORD_W=16 and CLB_BITS=300. The model is the overall bit
// stream: bit k of the word sequence must appear, in order, on the chain that
// owns index k, one bit per enable-high cycle.
// Optional build macro: CFG_CRC_CHECK_EN (a trailing CRC word is sent).
module tb_fabric_config_loader;

    localparam int CLB_A = 296, SB_N = 384, CB_N = 104, W_A = 8;
    localparam int TOT_A = CLB_A + SB_N + CB_N;
    localparam int NW_A  = (TOT_A + W_A - 1) / W_A;
    localparam int CLB_B = 300, W_B = 16;
    localparam int TOT_B = CLB_B + SB_N + CB_N;
    localparam int NW_B  = (TOT_B + W_B - 1) / W_B;
`ifdef CFG_CRC_CHECK_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic start_a, valid_a, ready_a, bclb_a, bsb_a, bcb_a, prgm_b_a;
    logic eclb_a, esb_a, ecb_a, busy_a, done_a_o, crc_err_a;
    logic [W_A-1:0] data_a;
    logic start_b, valid_b, ready_b, bclb_b, bsb_b, bcb_b, prgm_b_b;
    logic eclb_b, esb_b, ecb_b, busy_b, done_b_o, crc_err_b;
    logic [W_B-1:0] data_b;

    always #5 clk = ~clk;

    fabric_config_loader u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .cfg_data(data_a),
        .cfg_valid(valid_a), .cfg_ready(ready_a), .bit_in_clb(bclb_a),
        .bit_in_sb(bsb_a), .bit_in_cb(bcb_a), .prgm_b(prgm_b_a),
        .CLB_prgm_b(eclb_a), .sb_prgm_b(esb_a), .cb_prgm_b(ecb_a),
        .busy(busy_a), .done(done_a_o), .crc_err(crc_err_a)
    );

    fabric_config_loader #(.WORD_W(W_B), .CLB_BITS(CLB_B)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .cfg_data(data_b),
        .cfg_valid(valid_b), .cfg_ready(ready_b), .bit_in_clb(bclb_b),
        .bit_in_sb(bsb_b), .bit_in_cb(bcb_b), .prgm_b(prgm_b_b),
        .CLB_prgm_b(eclb_b), .sb_prgm_b(esb_b), .cb_prgm_b(ecb_b),
        .busy(busy_b), .done(done_b_o), .crc_err(crc_err_b)
    );

    int checks = 0, errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // CRC-8, poly 0x07, init 0, one message bit at a time.
    function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
        return (c << 1) ^ ((c[7] ^ b) ? 8'h07 : 8'h00);
    endfunction

    // Which chain owns stream bit k: 0 = CLB, 1 = SB, 2 = CB.
    function automatic int tgt(input int k, input int clb);
        if (k < clb) return 0;
        if (k < clb + SB_N) return 1;
        return 2;
    endfunction

    // ---------------- stream model ----------------
    logic [W_A-1:0] words_a[NW_A];
    bit             exp_a[TOT_A];
    logic [7:0]     crc_a;
    logic [W_B-1:0] words_b[NW_B];
    bit             exp_b[TOT_B];
    logic [7:0]     crc_b;

    task automatic build_a(input int seed);
        for (int i = 0; i < NW_A; i++)
            words_a[i] = W_A'(i * 29 + seed * 13 + 91) ^ W_A'(i >> 1);
        crc_a = 8'h00;
        for (int k = 0; k < TOT_A; k++) begin
            exp_a[k] = words_a[k / W_A][k % W_A];
            crc_a    = crc_step(crc_a, exp_a[k]);
        end
    endtask

    task automatic build_b();
        for (int i = 0; i < NW_B; i++)
            words_b[i] = W_B'(i * 4951 + 9320);
        // only the low 4 bits of the last word belong to the stream
        words_b[NW_B-1] = words_b[NW_B-1] | 16'hFFF0;
        crc_b = 8'h00;
        for (int k = 0; k < TOT_B; k++) begin
            exp_b[k] = words_b[k / W_B][k % W_B];
            crc_b    = crc_step(crc_b, exp_b[k]);
        end
    endtask

    // ---------------- compare process, instance A ----------------
    int k_a, acc_a, acc_prev_a, done_a, first_a, last_a, cyc;
    int cnt_a[3];
    bit exp_err_a;

    always @(negedge clk) begin
        int nen, t;
        bit b, other;
        cyc++;
        if (reset) begin
            k_a = 0; acc_a = 0; acc_prev_a = 0; cnt_a = '{0, 0, 0};
        end else begin
            if (start_a && !busy_a) begin
                k_a = 0; acc_a = 0; acc_prev_a = 0; cnt_a = '{0, 0, 0};
                first_a = -1; last_a = -1;
            end
            nen = int'(eclb_a) + int'(esb_a) + int'(ecb_a);
            chk("a_at_most_one_enable", nen > 1, 0);
            if (nen == 1) begin
                t     = eclb_a ? 0 : (esb_a ? 1 : 2);
                b     = (t == 0) ? bclb_a : ((t == 1) ? bsb_a : bcb_a);
                other = (t == 0) ? (bsb_a | bcb_a) : ((t == 1) ? (bclb_a | bcb_a) : (bclb_a | bsb_a));
                chk("a_shift_within_stream", k_a < TOT_A, 1);
                chk("a_shift_only_accepted_bits", k_a < acc_prev_a * W_A, 1);
                if (k_a < TOT_A) begin
                    chk("a_shift_target", t, tgt(k_a, CLB_A));
                    chk("a_shift_bit", b, exp_a[k_a]);
                end
                chk("a_idle_bits_zero", other, 0);
                cnt_a[t]++;
                if (first_a < 0) first_a = cyc;
                last_a = cyc;
                k_a++;
            end
            if (busy_a) chk("a_prgm_b_low_while_busy", prgm_b_a, 0);
            else        chk("a_no_enable_when_not_busy", nen, 0);
            if (done_a_o) begin
                done_a++;
                chk("a_done_prgm_b", prgm_b_a, 1);
                chk("a_done_busy", busy_a, 0);
                chk("a_done_bits_shifted", k_a, TOT_A);
                chk("a_done_crc_err", crc_err_a, exp_err_a);
            end
            acc_prev_a = acc_a;
            if (valid_a && ready_a) acc_a++;
        end
    end

    // ---------------- compare process, instance B ----------------
    int k_b, acc_b, done_b;
    int cnt_b[3];

    always @(negedge clk) begin
        int t;
        bit b;
        if (reset) begin
            k_b = 0; acc_b = 0; cnt_b = '{0, 0, 0};
        end else begin
            if (start_b && !busy_b) begin
                k_b = 0; acc_b = 0; cnt_b = '{0, 0, 0};
            end
            if (eclb_b || esb_b || ecb_b) begin
                t = eclb_b ? 0 : (esb_b ? 1 : 2);
                b = (t == 0) ? bclb_b : ((t == 1) ? bsb_b : bcb_b);
                chk("b_shift_within_stream", k_b < TOT_B, 1);
                if (k_b < TOT_B) begin
                    chk("b_shift_target", t, tgt(k_b, CLB_B));
                    chk("b_shift_bit", b, exp_b[k_b]);
                end
                cnt_b[t]++;
                k_b++;
            end
            if (done_b_o) begin
                done_b++;
                chk("b_done_crc_err", crc_err_b, 0);
            end
            if (valid_b && ready_b) acc_b++;
        end
    end

    // ---------------- drivers ----------------
    task automatic send_a(input logic [W_A-1:0] w, output bit ok);
        data_a = w; valid_a = 1'b1; ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_a) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [W_B-1:0] w, output bit ok);
        data_b = w; valid_b = 1'b1; ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (ready_b) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        valid_b = 1'b0;
    endtask

    // One configuration pass on A. gap_i: word index after which valid is
    // withheld long enough for the buffer to run dry (about 5 stall cycles).
    // abort_at >= 0: assert reset before that word and stop.
    task automatic run_a(input int gap1, input int gap2, input bit mid_start,
                         input bit flip, input int abort_at);
        int  d0, n;
        bit  ok;
        logic [W_A-1:0] w;
        d0 = done_a;
        exp_err_a = flip && (CRC_ON != 0);
        n = NW_A + CRC_ON;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1 reset = 1'b0;
                @(negedge clk);
                chk("abort_clb_en", eclb_a, 0);
                chk("abort_sb_en", esb_a, 0);
                chk("abort_cb_en", ecb_a, 0);
                chk("abort_prgm_b", prgm_b_a, 1);
                chk("abort_busy", busy_a, 0);
                chk("abort_cfg_ready", ready_a, 0);
                repeat (5) @(negedge clk);
                chk("abort_no_done", done_a - d0, 0);
                return;
            end
            if (mid_start && i == 5) start_a = 1'b1;
            w = (i < NW_A) ? words_a[i] : (crc_a ^ (flip ? 8'h01 : 8'h00));
            send_a(w, ok);
            start_a = 1'b0;
            chk("a_word_accepted_in_time", ok, 1);
            if (i == gap1 || i == gap2) begin
                repeat (13) @(posedge clk);
                #1;
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (done_a_o) begin ok = 1'b1; break; end
        end
        chk("a_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("a_done_once", done_a - d0, 1);
        chk("a_clb_enable_cycles", cnt_a[0], CLB_A);
        chk("a_sb_enable_cycles", cnt_a[1], SB_N);
        chk("a_cb_enable_cycles", cnt_a[2], CB_N);
        chk("a_words_accepted", acc_a, n);
        chk("a_idle_prgm_b", prgm_b_a, 1);
        if (gap1 < 0) chk("a_no_bubbles_span", last_a - first_a + 1, TOT_A);
        else          chk("a_gaps_stalled", (last_a - first_a + 1) > TOT_A, 1);
    endtask

    initial begin
        bit ok;
        logic [7:0] c, ch;
        string s;
        reset = 1'b1;
        start_a = 0; valid_a = 0; data_a = '0;
        start_b = 0; valid_b = 0; data_b = '0;

        // pins on the model itself
        chk("pin_tgt_a_295", tgt(295, CLB_A), 0);
        chk("pin_tgt_a_296", tgt(296, CLB_A), 1);
        chk("pin_tgt_a_679", tgt(679, CLB_A), 1);
        chk("pin_tgt_a_680", tgt(680, CLB_A), 2);
        chk("pin_tgt_b_684", tgt(684, CLB_B), 2);
        s = "123456789";
        c = 8'h00;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            for (int j = 7; j >= 0; j--) c = crc_step(c, ch[j]);
        end
        chk("pin_crc8_check_value", c, 8'hF4);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_prgm_b", prgm_b_a, 1);
        chk("rst_cfg_ready", ready_a, 0);
        chk("rst_enables", {eclb_a, esb_a, ecb_a}, 0);
        chk("rst_bits", {bclb_a, bsb_a, bcb_a}, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a_o, 0);
        chk("rst_crc_err", crc_err_a, 0);
        @(posedge clk); #1 reset = 1'b0;

        // cfg_valid in IDLE is not accepted
        valid_a = 1'b1; data_a = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("idle_cfg_ready_low", ready_a, 0);
        end
        @(posedge clk); #1 valid_a = 1'b0;

        // back-to-back, with a stray start during LOAD_CLB
        build_a(1);
        run_a(-1, -1, 1'b1, 1'b0, -1);
        // same stream with two dry spells; CRC word (if built) is corrupted
        run_a(36, 84, 1'b0, 1'b1, -1);
        // reset in the middle of the switch block chain, then a clean pass
        build_a(2);
        run_a(-1, -1, 1'b0, 1'b0, 50);
        run_a(-1, -1, 1'b0, 1'b0, -1);

        // wide words, odd CLB length: 50 words, last word mostly discarded
        build_b();
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < NW_B + CRC_ON; i++) begin
            send_b((i < NW_B) ? words_b[i] : {8'hC3, crc_b}, ok);
            chk("b_word_accepted_in_time", ok, 1);
        end
        ok = 1'b0;
        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            if (done_b_o) begin ok = 1'b1; break; end
        end
        chk("b_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("b_done_once", done_b, 1);
        chk("b_clb_enable_cycles", cnt_b[0], CLB_B);
        chk("b_sb_enable_cycles", cnt_b[1], SB_N);
        chk("b_cb_enable_cycles", cnt_b[2], CB_N);
        chk("b_bits_shifted", k_b, TOT_B);
        chk("b_words_accepted", acc_b, NW_B + CRC_ON);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, expected finish within 100000 cycles");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fabric_config_loader.md
Name: fabric_config_loader

Overview:
- Hardware replacement for the bench-driven configuration sequence.
- Accepts one packed configuration word stream over a valid/ready interface and serializes it, LSB first, into the CLB, switch block and connection block configuration shift chains, one chain at a time.
- Drives the global active-low prgm_b and the per-target shift enables CLB_prgm_b, sb_prgm_b and cb_prgm_b.
- Sits between the configuration memory/host interface and the fabric tile.

Parameters:
- CLB_BITS, 296, CLB chain length (8 LUTs x 37 bits).
- SB_BITS, 384, switch block chain length.
- CB_BITS, 104, connection block chain length (8 x 13 bits).
- WORD_W, 8, input word width; 1 to 32.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a full configuration; sampled only in IDLE.
- cfg_data  in  WORD_W  configuration word; bit 0 is shifted first.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts the word this cycle.
- bit_in_clb  out  1  serial bit to the CLB chain.
- bit_in_sb  out  1  serial bit to the switch block chain.
- bit_in_cb  out  1  serial bit to the connection block chain.
- prgm_b  out  1  global program strobe, active low.
- CLB_prgm_b  out  1  CLB shift enable, active high.
- sb_prgm_b  out  1  switch block shift enable, active high.
- cb_prgm_b  out  1  connection block shift enable, active high.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when all chains are loaded.
- crc_err  out  1  sticky error flag; see Optional Feature.

Behaviour:
- Reset values: prgm_b=1; cfg_ready, all enables, all bit_in_*, busy, done and crc_err = 0; state IDLE; all counters 0.
- Reset mid-load aborts immediately, with no partial completion.
- States: IDLE -> LOAD_CLB -> LOAD_SB -> LOAD_CB -> FINISH -> IDLE.
  - IDLE: start=1 -> LOAD_CLB. On that edge, busy=1, prgm_b=0 and crc_err is cleared.
  - start is ignored while busy.
- Word buffer: holds WORD_W bits plus a bit-remaining count.
  - cfg_ready=1 when the state is LOAD_* and the buffer is empty, or will empty this cycle (its last bit is being shifted).
  - A word is accepted on cfg_valid & cfg_ready.
- Bit stream is continuous across targets. Bit k of the overall stream goes to:
  - CLB for k < CLB_BITS,
  - SB for the next SB_BITS bits,
  - CB for the next CB_BITS bits.
- The defaults total 784 bits = 98 words of 8 bits. Unused high bits of the final word are discarded.
- Serializing, each cycle a buffered bit is available in LOAD_X:
  - the registered outputs bit_in_x = bit and X_prgm_b = 1 update together;
  - all other enables are 0 and all other bit_in_* are 0.
- Latency: a word accepted at edge N presents bit 0 after edge N+1. Targets shift on the following edge.
- Stall (buffer empty, no valid): the active enable drops to 0 and bit_in_x holds. Targets must not shift. prgm_b stays 0.
- Target transitions: after the last bit of a chain, the next state begins with no idle cycle when bits are available. The enable for the finished chain is 0 from then on.
- Each per-target bit counter has width $clog2(max BITS + 1). Enable-high cycles per target equal exactly *_BITS.
- FINISH: one cycle. prgm_b=1, done=1, busy=0 on the next edge, then IDLE.
- cfg_valid while not in LOAD_*: ignored, cfg_ready=0.

Optional Feature:
- CFG_CRC_CHECK_EN defined:
  - A serial CRC-8 (poly 0x07, init 0x00) is updated with every shifted configuration bit.
  - After LOAD_CB, state CHECK accepts one extra word; bits [7:0] hold the expected CRC.
  - On mismatch, crc_err=1 (sticky until the next start) and done still pulses.
  - WORD_W must be >= 8.
- Undefined: no CHECK state, no trailing word, crc_err tied 0.

Decomposition:
- Package fabric_cfg_pkg:
  - state enum (IDLE, LOAD_CLB, LOAD_SB, LOAD_CB, CHECK, FINISH);
  - default chain lengths;
  - CRC_POLY = 8'h07.
- One sub-module, cfg_word_serializer: word buffer, remaining count, cfg_ready generation, bit-pop handshake. The top holds the FSM, target counters, output registers and CRC.

Test Plan:
- Defaults, 98 words streamed back-to-back -> enable-high counts of 296/384/104; bits captured per chain match the stream; done pulses exactly once; prgm_b low throughout and returns to 1 on done.
- cfg_valid withheld 5 cycles, after word 37 and after word 85 -> no enable high during the gaps; captured chains are identical to the back-to-back run.
- reset=1 asserted mid LOAD_SB -> next cycle all enables 0, prgm_b=1, busy=0; a fresh start then completes normally.
- start pulsed during LOAD_CLB -> ignored; exactly one done pulse.
- WORD_W=16, CLB_BITS=300 (total 788 bits = 50 words) -> upper 12 bits of the last word discarded; CB count is 104.
- CFG_CRC_CHECK_EN with a correct CRC word -> crc_err=0; with one flipped bit -> crc_err=1 and done still pulses.
